c7bifu_iq: RTL and testbench
============================

Name: c7bifu_iq

Overview:
- Instruction queue between the instruction-fetch response path and the decode pipeline register (c7bifu_dec).
- Buffers fetched {pc, inst, fetch-exception} entries in a circular FIFO and presents the head entry as the `*_f` decode inputs.
- Absorbs decode stalls via backpressure to fetch; discards all contents on pipeline flush.
- Routes cache/fetch exceptions alongside the instruction so decode can raise them.

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.
- PTR_W, 2, log2(DEPTH); pointers carry one extra wrap bit (PTR_W+1 bits).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush (redirect/exception); synchronous.
- stall  in  1  decode/EXU stall; head entry must not be consumed.
- fch_iq_vld  in  1  fetch response valid.
- fch_iq_pc  in  32  fetch PC.
- fch_iq_inst  in  32  fetched instruction word.
- fch_iq_exc_vld  in  1  fetch/cache exception on this entry (e.g. ADEF, TLB refill).
- fch_iq_exc_code  in  6  exception code, meaningful when exc_vld=1.
- iq_fch_ready  out  1  queue can accept a push this cycle.
- inst_vld_f  out  1  head entry valid and handed to decode this cycle.
- inst_addr_f  out  32  head PC.
- inst_f  out  32  head instruction.
- iq_dec_exc_vld_f  out  1  head carries a fetch exception; qualified by inst_vld_f.
- iq_dec_exc_code_f  out  6  head exception code.
- iq_count  out  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset is asynchronous and active-high. While reset=1:
  - wr_ptr, rd_ptr and all entry storage = 0.
  - inst_vld_f = 0, iq_count = 0, iq_fch_ready = 1.
  - Data outputs = 0, exc outputs = 0.
  - Asserting reset mid-operation drops all entries immediately.
- Pointers:
  - (PTR_W+1)-bit wr_ptr and rd_ptr; entries are indexed by the low PTR_W bits.
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and wrap bits differ.
  - iq_count = wr_ptr - rd_ptr, modulo 2^(PTR_W+1).
- Push:
  - push = fch_iq_vld & iq_fch_ready & ~flush.
  - Writes {pc, inst, exc_vld, exc_code} at wr_ptr; wr_ptr increments.
  - fch_iq_vld while iq_fch_ready=0 is ignored; fetch must hold or replay the entry.
- Ready: iq_fch_ready = ~full, combinational from registered pointers only (no path from stall or fch_iq_vld).
- Pop:
  - inst_vld_f = ~empty & ~stall & ~flush.
  - pop = inst_vld_f; rd_ptr increments.
  - inst_addr_f, inst_f and exc fields always show the entry at rd_ptr, even when inst_vld_f=0.
  - Decode latches them only when inst_vld_f=1, so stall gating lives here, not in decode.
- Latency: no bypass. An entry pushed in cycle N is presented with inst_vld_f=1 at the earliest in cycle N+1.
- Simultaneous push and pop:
  - Legal when not full; count is unchanged.
  - When full, push is blocked by ready. A pop in that cycle frees a slot for cycle N+1, not N.
- Flush:
  - Synchronous. Next edge sets wr_ptr = rd_ptr = 0.
  - Same-cycle push and pop are suppressed; inst_vld_f=0 during the flush cycle.
  - Storage contents are left as-is, not cleared.
  - Flush has priority over stall, push and pop.
- Wrap-around:
  - Low pointer bits wrap from DEPTH-1 to 0; the wrap bit toggles.
  - Ordering is strictly FIFO across the wrap.
- Exceptions:
  - An entry with exc_vld=1 is queued and popped exactly like a normal entry.
  - Exception entries do not block later pushes; the IQ does not interpret them.
- Stall with empty queue: no effect; pushes continue until full.

Test Plan:
- Reset:
  - Stimulus: assert reset with 3 entries queued; release; push pc=0x1c000000, inst=0x02800421.
  - Required: during reset inst_vld_f=0, iq_count=0, outputs 0. After release, inst_vld_f=1 one cycle after the push, inst_addr_f=0x1c000000.
- Fill to full under stall:
  - Stimulus: stall=1, push 5 back-to-back entries, pc=0x100+4k.
  - Required: first 4 accepted; iq_fch_ready=0 after 4th; 5th ignored; iq_count=4.
  - Then: release stall. Required: pops pc 0x100, 0x104, 0x108, 0x10c in consecutive cycles.
- Simultaneous push/pop at steady state:
  - Stimulus: count=2, push every cycle, no stall, 10 cycles.
  - Required: count stays 2; output PCs strictly in push order across pointer wrap.
- Flush mid-stream:
  - Stimulus: count=3, assert flush together with fch_iq_vld=1.
  - Required: inst_vld_f=0 that cycle; next cycle count=0; flushed push not present.
  - Then: push pc=0x2000. Required: appears with inst_vld_f=1 one cycle later.
- Fetch exception:
  - Stimulus: push entry with exc_vld=1, code=0x08, between two normal entries.
  - Required: popped in order with iq_dec_exc_vld_f=1, code=0x08; neighbours show exc_vld=0.
- Stall toggling:
  - Stimulus: alternate stall 1/0 each cycle with 4 queued.
  - Required: inst_vld_f high only in stall=0 cycles; each entry presented exactly once; rd_ptr advances only on those cycles.

Source files
------------

// File: rtl/c7bifu_iq_if.sv
// c7bifu instruction queue bus: fetch push side and decode head side.
// master = fetch/decode environment, slave = the queue itself.
interface c7bifu_iq_if #(
    parameter int PTR_W = 2
);
    logic             fch_iq_vld;
    logic [31:0]      fch_iq_pc;
    logic [31:0]      fch_iq_inst;
    logic             fch_iq_exc_vld;
    logic [5:0]       fch_iq_exc_code;
    logic             iq_fch_ready;
    logic             inst_vld_f;
    logic [31:0]      inst_addr_f;
    logic [31:0]      inst_f;
    logic             iq_dec_exc_vld_f;
    logic [5:0]       iq_dec_exc_code_f;
    logic [PTR_W:0]   iq_count;

    modport master (
        output fch_iq_vld, fch_iq_pc, fch_iq_inst,
        output fch_iq_exc_vld, fch_iq_exc_code,
        input  iq_fch_ready, inst_vld_f, inst_addr_f, inst_f,
        input  iq_dec_exc_vld_f, iq_dec_exc_code_f, iq_count
    );

    modport slave (
        input  fch_iq_vld, fch_iq_pc, fch_iq_inst,
        input  fch_iq_exc_vld, fch_iq_exc_code,
        output iq_fch_ready, inst_vld_f, inst_addr_f, inst_f,
        output iq_dec_exc_vld_f, iq_dec_exc_code_f, iq_count
    );
endinterface

// File: rtl/c7bifu_iq.sv
// c7bifu instruction queue: circular FIFO of {pc, inst, exc} between
// fetch response and decode, with stall backpressure and flush discard.
module c7bifu_iq #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          stall,
    c7bifu_iq_if.slave    iq
);
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic [31:0]      r_pc       [DEPTH];
    logic [31:0]      r_inst     [DEPTH];
    logic             r_exc_vld  [DEPTH];
    logic [5:0]       r_exc_code [DEPTH];

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_wr_idx;
    logic [PTR_W-1:0] w_rd_idx;

    assign w_wr_idx = r_wr_ptr[PTR_W-1:0];
    assign w_rd_idx = r_rd_ptr[PTR_W-1:0];
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (w_wr_idx == w_rd_idx) &&
                      (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);

    // Ready depends only on registered pointers, never on stall/vld.
    assign iq.iq_fch_ready = ~w_full;
    assign w_push = iq.fch_iq_vld & ~w_full & ~flush;
    assign w_pop  = ~w_empty & ~stall & ~flush;

    assign iq.inst_vld_f        = w_pop;
    assign iq.inst_addr_f       = r_pc[w_rd_idx];
    assign iq.inst_f            = r_inst[w_rd_idx];
    assign iq.iq_dec_exc_vld_f  = r_exc_vld[w_rd_idx];
    assign iq.iq_dec_exc_code_f = r_exc_code[w_rd_idx];
    assign iq.iq_count          = r_wr_ptr - r_rd_ptr;

    // Pointer update; flush outranks push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Entry storage; flush leaves contents untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]       <= '0;
                r_inst[i]     <= '0;
                r_exc_vld[i]  <= 1'b0;
                r_exc_code[i] <= '0;
            end
        end else if (w_push) begin
            r_pc[w_wr_idx]       <= iq.fch_iq_pc;
            r_inst[w_wr_idx]     <= iq.fch_iq_inst;
            r_exc_vld[w_wr_idx]  <= iq.fch_iq_exc_vld;
            r_exc_code[w_wr_idx] <= iq.fch_iq_exc_code;
        end
    end
endmodule

// File: tb/tb_c7bifu_iq.sv
// Directed bench for c7bifu_iq with a queue scoreboard of expected
// entries, checked every cycle on the falling edge.
module tb_c7bifu_iq;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ev;
        logic [5:0]  ec;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic stall;
    int   checks = 0;
    int   errors = 0;
    ent_t sb[$];

    c7bifu_iq_if #(.PTR_W(PTR_W)) bus ();

    c7bifu_iq #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .stall (stall),
        .iq    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic ev, input logic [5:0] ec);
        bus.fch_iq_vld      = v;
        bus.fch_iq_pc       = pc;
        bus.fch_iq_inst     = pc ^ 32'h0280_0421;
        bus.fch_iq_exc_vld  = ev;
        bus.fch_iq_exc_code = ec;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 6'h0);
    endtask

    task automatic chk_reset_outs();
        chk("rst_ready", bus.iq_fch_ready, 1);
        chk("rst_vld", bus.inst_vld_f, 0);
        chk("rst_count", bus.iq_count, 0);
        chk("rst_addr", bus.inst_addr_f, 0);
        chk("rst_inst", bus.inst_f, 0);
        chk("rst_ev", bus.iq_dec_exc_vld_f, 0);
        chk("rst_ec", bus.iq_dec_exc_code_f, 0);
    endtask

    // One cycle: compare DUT against scoreboard, then advance model.
    task automatic cyc();
        ent_t e;
        bit   rdy;
        bit   evld;
        @(negedge clk);
        rdy  = sb.size() < DEPTH;
        evld = (sb.size() != 0) && !stall && !flush;
        chk("ready", bus.iq_fch_ready, rdy);
        chk("count", bus.iq_count, sb.size());
        chk("vld", bus.inst_vld_f, evld);
        if (sb.size() != 0) begin
            chk("head_pc", bus.inst_addr_f, sb[0].pc);
            chk("head_inst", bus.inst_f, sb[0].inst);
            chk("head_ev", bus.iq_dec_exc_vld_f, sb[0].ev);
            chk("head_ec", bus.iq_dec_exc_code_f, sb[0].ec);
        end
        if (evld) void'(sb.pop_front());
        if (bus.fch_iq_vld && rdy && !flush) begin
            e.pc   = bus.fch_iq_pc;
            e.inst = bus.fch_iq_inst;
            e.ev   = bus.fch_iq_exc_vld;
            e.ec   = bus.fch_iq_exc_code;
            sb.push_back(e);
        end
        if (flush) sb.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        stall = 1'b0;
        idle();
        @(negedge clk);
        chk_reset_outs();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Queue 3 entries, then reset drops them asynchronously.
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h50 + 4 * k, 1'b0, 6'h0);
            cyc();
        end
        idle();
        chk("pre_rst_count", bus.iq_count, 3);
        reset = 1'b1;
        #1;
        chk_reset_outs();
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        stall = 1'b0;
        drive(1'b1, 32'h1c00_0000, 1'b0, 6'h0);
        bus.fch_iq_inst = 32'h0280_0421;
        cyc();
        idle();
        @(negedge clk);
        chk("post_rst_vld", bus.inst_vld_f, 1);
        chk("post_rst_pc", bus.inst_addr_f, 32'h1c00_0000);
        chk("post_rst_inst", bus.inst_f, 32'h0280_0421);
        @(posedge clk);
        #1;
        void'(sb.pop_front());

        // Fill to full under stall; the 5th push is ignored.
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h100 + 4 * k, 1'b0, 6'h0);
            cyc();
        end
        idle();
        chk("full_ready", bus.iq_fch_ready, 0);
        chk("full_count", bus.iq_count, 4);
        stall = 1'b0;
        for (int k = 0; k < 5; k++) cyc();

        // Steady state: count 2 with push and pop every cycle.
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h300 + 4 * k, 1'b0, 6'h0);
            cyc();
        end
        stall = 1'b0;
        for (int k = 2; k < 12; k++) begin
            drive(1'b1, 32'h300 + 4 * k, 1'b0, 6'h0);
            cyc();
            chk("steady_count", bus.iq_count, 2);
        end
        idle();
        for (int k = 0; k < 3; k++) cyc();

        // Flush with a concurrent push and 3 queued.
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h400 + 4 * k, 1'b0, 6'h0);
            cyc();
        end
        stall = 1'b0;
        flush = 1'b1;
        drive(1'b1, 32'hdead_0000, 1'b0, 6'h0);
        cyc();
        flush = 1'b0;
        idle();
        chk("flush_count", bus.iq_count, 0);
        drive(1'b1, 32'h2000, 1'b0, 6'h0);
        cyc();
        idle();
        cyc();
        cyc();

        // Exception entry between two normal entries.
        drive(1'b1, 32'h600, 1'b0, 6'h0);
        cyc();
        drive(1'b1, 32'h604, 1'b1, 6'h08);
        cyc();
        drive(1'b1, 32'h608, 1'b0, 6'h0);
        cyc();
        idle();
        for (int k = 0; k < 2; k++) cyc();

        // Stall toggling with 4 queued.
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h700 + 4 * k, k == 2, 6'h0c);
            cyc();
        end
        idle();
        for (int k = 0; k < 10; k++) begin
            stall = (k % 2 == 0);
            cyc();
        end
        stall = 1'b0;
        cyc();
        chk("final_empty", bus.iq_count, 0);
        chk("final_sb", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
